// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART definitions. Holds the receiver state encoding
//                and the baud divisor function that the transmitter also
//                uses, so both ends of the link derive the same bit period.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

  // Receiver state encoding
  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4
  } uart_rx_state_t;

  // Clock cycles per serial bit, truncating division.
  function automatic int unsigned uart_clks_per_bit(input int unsigned clock_hz,
                                                    input int unsigned baud);
    return clock_hz / baud;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo
//  Description : Generic byte FIFO with push/full and pop/valid handshakes.
//                Circular buffer with read/write pointers and an occupancy
//                count. A pop and a push in the same cycle on a full buffer
//                both succeed: the pop frees the slot the push writes into.
//                The head entry is presented directly from storage, so it is
//                stable until popped and the next entry appears one cycle
//                after a pop.
//  Ports       : clk        - clock
//                rst        - asynchronous active-high reset (empties FIFO)
//                i_push     - write request
//                i_data     - write data
//                o_full     - FIFO holds DEPTH entries
//                i_pop      - read request (ignored when empty)
//                o_data     - head entry (0x00 after reset)
//                o_valid    - FIFO not empty
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  logic [7:0] i_data,
  output logic       o_full,
  input  logic       i_pop,
  output logic [7:0] o_data,
  output logic       o_valid
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  localparam logic [AW-1:0] c_last_ptr = AW'(DEPTH - 1);
  localparam logic [CW-1:0] c_depth    = CW'(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_wr;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_depth);
  assign w_pop   = i_pop && !w_empty;
  // A simultaneous pop makes room, so a push into a full buffer still lands.
  assign w_wr    = i_push && (!w_full || w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= (r_wptr == c_last_ptr) ? '0 : r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == c_last_ptr) ? '0 : r_rptr + 1'b1;
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_full  = w_full;
  assign o_data  = r_mem[r_rptr];
  assign o_valid = !w_empty;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 8N1 UART receiver. The serial input is synchronized, frames
//                are sampled at mid-bit using a per-bit cycle counter, and
//                received bytes are delivered on a valid/ready interface.
//                Stop-bit failures raise frame_err; bytes arriving at a full
//                buffer are dropped and raise overrun.
//  Config      : UART_RX_FIFO_EN defined   -> FIFO_DEPTH-entry receive FIFO
//                UART_RX_FIFO_EN undefined -> single holding register
//  Ports       : clk_cpu   - block clock
//                reset     - asynchronous active-high reset
//                rx_pin    - serial line, idle high, asynchronous
//                rd_data   - head received byte
//                rd_valid  - rd_data holds an unread byte
//                rd_ready  - consumer accepts rd_data when rd_valid is high
//                frame_err - one-cycle pulse, stop bit sampled low
//                overrun   - one-cycle pulse, good byte dropped (buffer full)
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned UART_CLOCK_HZ = 20_000_000,
  parameter int unsigned UART_BAUD     = 115200,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic       clk_cpu,
  input  logic       reset,
  input  logic       rx_pin,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  input  logic       rd_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned CLKS_PER_BIT = uart_clks_per_bit(UART_CLOCK_HZ, UART_BAUD);
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] c_half_last = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] c_bit_last  = CNT_W'(CLKS_PER_BIT - 1);

`ifdef UART_RX_FIFO_EN
  localparam bit c_fifo_en = 1'b1;
`else
  localparam bit c_fifo_en = 1'b0;
`endif

  if (CLKS_PER_BIT < 4) begin : g_cpb_check
    $error("uart_rx: CLKS_PER_BIT must be at least 4");
  end

  if (c_fifo_en && ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)))
  begin : g_depth_check
    $error("uart_rx: FIFO_DEPTH must be a power of two, at least 2");
  end

  // --------------------------------------------------------------------------
  // Input synchronizer; resets to the idle line level so reset release does
  // not look like a start edge.
  // --------------------------------------------------------------------------
  logic r_sync1;
  logic r_sync2;
  logic w_rx_s;

  always_ff @(posedge clk_cpu or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx_pin;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx_s = r_sync2;

  // --------------------------------------------------------------------------
  // Frame FSM
  // --------------------------------------------------------------------------
  uart_rx_state_t   r_state;
  uart_rx_state_t   w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [2:0]       r_bit_idx;
  logic [2:0]       w_bit_idx_nxt;
  logic [7:0]       r_shift;
  logic [7:0]       w_shift_nxt;
  logic             w_push;
  logic             w_ferr;

  always_ff @(posedge clk_cpu or posedge reset) begin
    if (reset) begin
      r_state   <= RX_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt + 1'b1;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_push        = 1'b0;
    w_ferr        = 1'b0;

    case (r_state)
      RX_IDLE: begin
        w_cnt_nxt     = '0;
        w_bit_idx_nxt = '0;
        if (!w_rx_s) begin
          w_state_nxt = RX_START;
        end
      end

      // Re-check the line at the middle of the start bit; a line that has
      // already returned high was a glitch.
      RX_START: begin
        if (r_cnt == c_half_last) begin
          w_cnt_nxt   = '0;
          w_state_nxt = w_rx_s ? RX_IDLE : RX_DATA;
        end
      end

      RX_DATA: begin
        if (r_cnt == c_bit_last) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {w_rx_s, r_shift[7:1]};
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = RX_STOP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 1'b1;
          end
        end
      end

      // Returning to IDLE at the stop-bit midpoint leaves half a bit of
      // margin to catch a back-to-back start edge.
      RX_STOP: begin
        if (r_cnt == c_bit_last) begin
          w_cnt_nxt = '0;
          if (w_rx_s) begin
            w_push      = 1'b1;
            w_state_nxt = RX_IDLE;
          end else begin
            w_ferr      = 1'b1;
            w_state_nxt = RX_BREAK;
          end
        end
      end

      // A line held low after a bad stop bit must not be re-read as frames.
      RX_BREAK: begin
        w_cnt_nxt = '0;
        if (w_rx_s) begin
          w_state_nxt = RX_IDLE;
        end
      end

      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = RX_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Receive buffer
  // --------------------------------------------------------------------------
  logic w_pop;
  logic w_full;

  assign w_pop = rd_valid && rd_ready;

`ifdef UART_RX_FIFO_EN
  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk_cpu),
    .rst     (reset),
    .i_push  (w_push),
    .i_data  (r_shift),
    .o_full  (w_full),
    .i_pop   (w_pop),
    .o_data  (rd_data),
    .o_valid (rd_valid)
  );
`else
  logic [7:0] r_hold_data;
  logic       r_hold_valid;
  logic       w_accept;

  assign w_full   = r_hold_valid;
  assign w_accept = w_push && (!r_hold_valid || w_pop);

  always_ff @(posedge clk_cpu or posedge reset) begin
    if (reset) begin
      r_hold_data  <= '0;
      r_hold_valid <= 1'b0;
    end else if (w_accept) begin
      r_hold_data  <= r_shift;
      r_hold_valid <= 1'b1;
    end else if (w_pop) begin
      r_hold_valid <= 1'b0;
    end
  end

  assign rd_data  = r_hold_data;
  assign rd_valid = r_hold_valid;
`endif

  // --------------------------------------------------------------------------
  // Status pulses
  // --------------------------------------------------------------------------
  logic r_frame_err;
  logic r_overrun;

  always_ff @(posedge clk_cpu or posedge reset) begin
    if (reset) begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_ferr;
      // A pop in the same cycle frees a slot, so that push is not dropped.
      r_overrun   <= w_push && w_full && !w_pop;
    end
  end

  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Self-checking bench for uart_rx at default parameters.
//                Expected bytes are queued when frames are driven and
//                compared against bytes the receiver hands over.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_rx;

  localparam int CPB  = 173;
  localparam int HALF = 86;
`ifdef UART_RX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic       clk_cpu  = 1'b0;
  logic       reset    = 1'b1;
  logic       rx_pin   = 1'b1;
  logic       rd_ready = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       frame_err;
  logic       overrun;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] sb_q  [$];
  logic [7:0] obs_q [$];
  int         ferr_cnt = 0;
  int         ovr_cnt  = 0;

  uart_rx dut (
    .clk_cpu   (clk_cpu),
    .reset     (reset),
    .rx_pin    (rx_pin),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk_cpu = ~clk_cpu;

  // Observer: bytes handed over, status pulse cycles
  always begin
    @(negedge clk_cpu);
    #1;
    if (rd_valid === 1'b1 && rd_ready === 1'b1) obs_q.push_back(rd_data);
    if (frame_err === 1'b1) ferr_cnt++;
    if (overrun === 1'b1) ovr_cnt++;
  end

  // Called right after a negedge; returns at the negedge ending the stop bit.
  task automatic send_frame(input logic [7:0] b);
    rx_pin = 1'b0;
    repeat (CPB) @(negedge clk_cpu);
    for (int i = 0; i < 8; i++) begin
      rx_pin = b[i];
      repeat (CPB) @(negedge clk_cpu);
    end
    rx_pin = 1'b1;
    repeat (CPB) @(negedge clk_cpu);
  endtask

  task automatic clear_sb();
    sb_q.delete();
    obs_q.delete();
    ferr_cnt = 0;
    ovr_cnt  = 0;
  endtask

  task automatic drain();
    rd_ready = 1'b1;
    repeat (DEPTH + 6) @(negedge clk_cpu);
    rd_ready = 1'b0;
    repeat (2) @(negedge clk_cpu);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (4) @(negedge clk_cpu);
    vectors++;
    if ({rd_valid, rd_data, frame_err, overrun} !== 11'd0) begin
      $display("FAIL reset_outputs: got valid=%b data=%h ferr=%b ovr=%b expected all 0",
               rd_valid, rd_data, frame_err, overrun);
      miscompares++;
    end
    reset = 1'b0;
    repeat (2 * CPB) @(negedge clk_cpu);
    vectors++;
    if ({rd_valid, rd_data, frame_err, overrun} !== 11'd0 || ferr_cnt != 0) begin
      $display("FAIL idle_after_reset: got valid=%b data=%h ferr_cnt=%0d expected idle",
               rd_valid, rd_data, ferr_cnt);
      miscompares++;
    end
  endtask

  task automatic test_single_byte();
    int         lat;
    logic [7:0] exp;
    clear_sb();
    lat = -1;
    @(negedge clk_cpu);
    sb_q.push_back(8'h48);
    fork
      send_frame(8'h48);
      begin
        for (int k = 1; k <= 2000; k++) begin
          @(negedge clk_cpu);
          if (rd_valid === 1'b1) begin
            lat = k;
            break;
          end
        end
      end
    join
    vectors++;
    if (lat != 2 + HALF + 9 * CPB + 1) begin
      $display("FAIL single_latency: got %0d cycles expected %0d", lat, 2 + HALF + 9 * CPB + 1);
      miscompares++;
    end
    exp = sb_q.pop_front();
    repeat (20) @(negedge clk_cpu);
    vectors++;
    if (rd_valid !== 1'b1 || rd_data !== exp) begin
      $display("FAIL single_data: got valid=%b data=%h expected valid=1 data=%h",
               rd_valid, rd_data, exp);
      miscompares++;
    end
    rd_ready = 1'b1;
    @(negedge clk_cpu);
    rd_ready = 1'b0;
    vectors++;
    if (rd_valid !== 1'b0) begin
      $display("FAIL single_pop: got valid=%b expected 0", rd_valid);
      miscompares++;
    end
    vectors++;
    if (obs_q.size() != 1 || ferr_cnt != 0) begin
      $display("FAIL single_handover: got %0d pops ferr=%0d expected 1 pop ferr=0",
               obs_q.size(), ferr_cnt);
      miscompares++;
    end
  endtask

  task automatic test_glitch();
    logic [7:0] exp;
    logic [7:0] got;
    clear_sb();
    @(negedge clk_cpu);
    rx_pin = 1'b0;
    repeat (40) @(negedge clk_cpu);
    rx_pin = 1'b1;
    repeat (3 * CPB) @(negedge clk_cpu);
    vectors++;
    if (rd_valid !== 1'b0 || ferr_cnt != 0) begin
      $display("FAIL glitch_reject: got valid=%b ferr=%0d expected 0 and 0", rd_valid, ferr_cnt);
      miscompares++;
    end
    sb_q.push_back(8'h3C);
    send_frame(8'h3C);
    drain();
    while (sb_q.size() > 0) begin
      exp = sb_q.pop_front();
      got = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
      vectors++;
      if (got !== exp) begin
        $display("FAIL glitch_next_frame: got %h expected %h", got, exp);
        miscompares++;
      end
    end
  endtask

  task automatic test_framing_error();
    logic [7:0] pat;
    logic [7:0] exp;
    logic [7:0] got;
    clear_sb();
    pat = 8'h55;
    @(negedge clk_cpu);
    rx_pin = 1'b0;
    repeat (CPB) @(negedge clk_cpu);
    for (int i = 0; i < 8; i++) begin
      rx_pin = pat[i];
      repeat (CPB) @(negedge clk_cpu);
    end
    rx_pin = 1'b0;
    repeat (3 * CPB) @(negedge clk_cpu);
    rx_pin = 1'b1;
    repeat (2 * CPB) @(negedge clk_cpu);
    vectors++;
    if (ferr_cnt != 1) begin
      $display("FAIL ferr_pulse: got %0d frame_err cycles expected 1", ferr_cnt);
      miscompares++;
    end
    vectors++;
    if (rd_valid !== 1'b0) begin
      $display("FAIL ferr_discard: got valid=%b expected 0", rd_valid);
      miscompares++;
    end
    sb_q.push_back(8'hA5);
    send_frame(8'hA5);
    drain();
    while (sb_q.size() > 0) begin
      exp = sb_q.pop_front();
      got = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
      vectors++;
      if (got !== exp) begin
        $display("FAIL ferr_next_frame: got %h expected %h", got, exp);
        miscompares++;
      end
    end
  endtask

  task automatic test_overrun();
    int         exp_ovr;
    logic [7:0] exp;
    logic [7:0] got;
    clear_sb();
    exp_ovr = 0;
    rd_ready = 1'b0;
    @(negedge clk_cpu);
    for (int i = 1; i <= 5; i++) begin
      if (sb_q.size() < DEPTH) sb_q.push_back(8'(i));
      else exp_ovr++;
      send_frame(8'(i));
    end
    repeat (5) @(negedge clk_cpu);
    vectors++;
    if (ovr_cnt != exp_ovr) begin
      $display("FAIL overrun_count: got %0d expected %0d", ovr_cnt, exp_ovr);
      miscompares++;
    end
    drain();
    while (sb_q.size() > 0) begin
      exp = sb_q.pop_front();
      got = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
      vectors++;
      if (got !== exp) begin
        $display("FAIL overrun_drain: got %h expected %h", got, exp);
        miscompares++;
      end
    end
    vectors++;
    if (obs_q.size() != 0) begin
      $display("FAIL overrun_extra: got %0d extra bytes expected 0", obs_q.size());
      miscompares++;
    end
  endtask

  task automatic test_full_pop();
    logic [7:0] exp;
    logic [7:0] got;
    clear_sb();
    rd_ready = 1'b0;
    @(negedge clk_cpu);
    for (int i = 0; i < DEPTH; i++) begin
      sb_q.push_back(8'h10 + 8'(i));
      send_frame(8'h10 + 8'(i));
    end
    // The last byte is pushed while the full buffer is being popped.
    sb_q.push_back(8'hE7);
    fork
      send_frame(8'hE7);
      begin
        repeat (2 + HALF + 9 * CPB - 1) @(negedge clk_cpu);
        rd_ready = 1'b1;
      end
    join
    repeat (DEPTH + 4) @(negedge clk_cpu);
    rd_ready = 1'b0;
    repeat (2) @(negedge clk_cpu);
    vectors++;
    if (ovr_cnt != 0) begin
      $display("FAIL fullpop_overrun: got %0d expected 0", ovr_cnt);
      miscompares++;
    end
    while (sb_q.size() > 0) begin
      exp = sb_q.pop_front();
      got = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
      vectors++;
      if (got !== exp) begin
        $display("FAIL fullpop_order: got %h expected %h", got, exp);
        miscompares++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] pats [4];
    logic [7:0] exp;
    logic [7:0] got;
    clear_sb();
    pats[0] = 8'h00;
    pats[1] = 8'hFF;
    pats[2] = 8'h5A;
    pats[3] = 8'h81;
    rd_ready = 1'b1;
    @(negedge clk_cpu);
    for (int i = 0; i < 4; i++) begin
      sb_q.push_back(pats[i]);
      send_frame(pats[i]);
    end
    repeat (5) @(negedge clk_cpu);
    rd_ready = 1'b0;
    vectors++;
    if (ovr_cnt != 0 || ferr_cnt != 0) begin
      $display("FAIL b2b_flags: got ovr=%0d ferr=%0d expected 0 and 0", ovr_cnt, ferr_cnt);
      miscompares++;
    end
    while (sb_q.size() > 0) begin
      exp = sb_q.pop_front();
      got = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
      vectors++;
      if (got !== exp) begin
        $display("FAIL b2b_data: got %h expected %h", got, exp);
        miscompares++;
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] pat;
    logic [7:0] exp;
    logic [7:0] got;
    clear_sb();
    pat = 8'hC3;
    rd_ready = 1'b0;
    @(negedge clk_cpu);
    send_frame(8'h11);
    repeat (5) @(negedge clk_cpu);
    vectors++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h11) begin
      $display("FAIL rst_preload: got valid=%b data=%h expected valid=1 data=11", rd_valid, rd_data);
      miscompares++;
    end
    // Partial frame, reset lands in the middle of data bit 3
    rx_pin = 1'b0;
    repeat (CPB) @(negedge clk_cpu);
    for (int i = 0; i < 3; i++) begin
      rx_pin = pat[i];
      repeat (CPB) @(negedge clk_cpu);
    end
    rx_pin = pat[3];
    repeat (CPB / 2) @(negedge clk_cpu);
    reset = 1'b1;
    #1;
    vectors++;
    if ({rd_valid, rd_data, frame_err, overrun} !== 11'd0) begin
      $display("FAIL rst_mid_frame: got valid=%b data=%h ferr=%b ovr=%b expected all 0",
               rd_valid, rd_data, frame_err, overrun);
      miscompares++;
    end
    rx_pin = 1'b1;
    repeat (5) @(negedge clk_cpu);
    reset = 1'b0;
    repeat (2 * CPB) @(negedge clk_cpu);
    vectors++;
    if (rd_valid !== 1'b0 || ferr_cnt != 0) begin
      $display("FAIL rst_no_recover: got valid=%b ferr=%0d expected 0 and 0", rd_valid, ferr_cnt);
      miscompares++;
    end
    clear_sb();
    sb_q.push_back(8'h7E);
    send_frame(8'h7E);
    drain();
    while (sb_q.size() > 0) begin
      exp = sb_q.pop_front();
      got = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
      vectors++;
      if (got !== exp) begin
        $display("FAIL rst_next_frame: got %h expected %h", got, exp);
        miscompares++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_glitch();
    test_framing_error();
    test_overrun();
    test_full_pop();
    test_back_to_back();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
# uart_rx

Synthesizable UART receiver. It is the consumer of the SoC's `uart_tx_pin` serial stream, and it gives the SoC a loop-back and console input path. 8N1 frames are sampled at mid-bit with a per-bit clock counter, then bytes are delivered over a valid/ready interface. Framing errors and overruns are flagged.

## Interface
- `UART_CLOCK_HZ`, default 20_000_000: `clk_cpu` frequency.
- `UART_BAUD`, default 115200: line rate.
- `FIFO_DEPTH`, default 4: receive buffer entries; power of two, ≥2. Only used with `UART_RX_FIFO_EN`.
- `clk_cpu`, in, 1: the block's single clock.
- `reset`, in, 1: asynchronous, active-high.
- `rx_pin`, in, 1: serial line, idle high, asynchronous to `clk_cpu`.
- `rd_data`, out, 8: received byte, head of buffer.
- `rd_valid`, out, 1: `rd_data` holds an unread byte.
- `rd_ready`, in, 1: consumer accepts `rd_data` on a cycle where `rd_valid && rd_ready`.
- `frame_err`, out, 1: one-cycle pulse when the stop bit is sampled low.
- `overrun`, out, 1: one-cycle pulse when a good byte is dropped because the buffer is full.

## Operation
- `CLKS_PER_BIT = UART_CLOCK_HZ / UART_BAUD`, integer truncation (173 at defaults). `HALF_BIT = CLKS_PER_BIT / 2` (86).
- Elaboration error if `CLKS_PER_BIT < 4`.
- `rx_pin` passes through a 2-flop synchronizer; both flops reset to 1. All decisions use the synchronized value `rx_s`.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: `rx_s == 0` → START, bit counter cleared.
  - START: after `HALF_BIT` cycles, sample `rx_s`. If 1, treat as a glitch → IDLE, no flags. If 0 → DATA.
  - DATA: every `CLKS_PER_BIT` cycles, sample `rx_s` into the shift register, LSB first. After the 8th sample → STOP.
  - STOP: after `CLKS_PER_BIT` cycles, sample `rx_s`.
    - Sampled 1: push the byte → IDLE.
    - Sampled 0: pulse `frame_err`, discard the byte → BREAK.
  - BREAK: wait for `rx_s == 1` → IDLE. This stops a held-low line from generating repeated frames.
- Push into a full buffer: the byte is dropped, `overrun` pulses, and the buffer contents are unchanged.
- Push and pop in the same cycle on a full buffer: the pop takes effect first, the push succeeds, and there is no overrun.
- Pop on an empty buffer is impossible, because `rd_valid` is 0.
- Reset, asserted at any time including mid-frame:
  - FSM goes to IDLE, counters go to 0, buffer is emptied.
  - Outputs: `rd_valid`=0, `rd_data`=0x00, `frame_err`=0, `overrun`=0.
  - A frame already in progress when reset releases is not recovered. The next falling edge starts a clean frame.

## Timing
- Start-edge detection lags `rx_pin` by 2 cycles (synchronizer).
- Stop-bit sample occurs `HALF_BIT + 9*CLKS_PER_BIT` cycles after IDLE sees `rx_s == 0`.
- `rd_valid` (or the `frame_err` pulse) rises on the cycle after the stop-bit sample.
- `rd_data` and `rd_valid` are registered and stay stable until they are popped.
- After a pop, the next entry is presented on the following cycle.
- `frame_err` and `overrun` are registered, high for exactly one cycle.
- Back-to-back frames are supported. IDLE is re-entered at the stop-bit midpoint, leaving a half-bit of margin for the next start edge.

## Configuration
- `UART_RX_FIFO_EN` defined: a `FIFO_DEPTH`-entry circular buffer with read/write pointers and a count of width `$clog2(FIFO_DEPTH)+1`. Pointers wrap modulo `FIFO_DEPTH`.
- `UART_RX_FIFO_EN` undefined: a single holding register, so `FIFO_DEPTH` is ignored and the effective depth is 1. A second byte that arrives before the pop causes `overrun`.

## Structure
- `uart_pkg` contains:
  - The state enum `uart_rx_state_t`.
  - A function `uart_clks_per_bit(clock_hz, baud)`, shared with the transmitter so both ends compute an identical divisor.
- Sub-module `uart_rx_fifo`: generic byte FIFO with push/full/pop/valid. It is instantiated only under `UART_RX_FIFO_EN`; `uart_rx` contains the FSM and synchronizer.

## Test plan
All scenarios run at default parameters (173 clocks/bit).
- **Single byte:** drive 8N1 frame 0x48 ('H'), `rd_ready`=0 → `rd_valid` rises `2+86+9*173+1` cycles after the falling edge, `rd_data`=0x48; asserting `rd_ready` for 1 cycle drops `rd_valid`.
- **Glitch rejection:** pulse `rx_pin` low for 40 cycles → no `rd_valid`, no `frame_err`, FSM back in IDLE.
- **Framing error:** frame 0x55 with a stop bit of 0, held low 3 bit times then high → exactly one `frame_err` pulse, `rd_valid` stays 0, then the next frame 0xA5 is received correctly.
- **Overrun:** with `UART_RX_FIFO_EN` defined, send 5 back-to-back bytes 0x01..0x05 with `rd_ready`=0 → one `overrun` pulse on the 5th; draining yields 0x01..0x04.
- **Full plus simultaneous pop:** fill the buffer, hold `rd_ready`=1 from the cycle the 5th byte is pushed → no `overrun`, all 5 bytes read in order.
- **Reset mid-frame:** assert `reset` during DATA bit 3 of a frame → all outputs 0 immediately; after release, frame 0x7E is received correctly.
